numero_decoder: RTL

NUMERO_DECODER -- requirements
Module: numero_decoder

---
 rtl/numero_if.sv | 23 ++
 rtl/numero_decoder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/numero_if.sv
// Bundle of the digit-encoder inputs and decoded outputs of numero_decoder.
// master drives the encoder side; slave is the decoder.
interface numero_if;
  logic        d1, d2, d3, d4, d5;
  logic        ready;
  logic        clear;
  logic        A, B, C, D;
  logic        valid;
  logic        Ativa_vermelho;
  logic [15:0] value;
  logic [2:0]  count;
  logic        full;

  modport master (
    output d1, d2, d3, d4, d5, ready, clear,
    input  A, B, C, D, valid, Ativa_vermelho, value, count, full
  );

  modport slave (
    input  d1, d2, d3, d4, d5, ready, clear,
    output A, B, C, D, valid, Ativa_vermelho, value, count, full
  );
endinterface

// File: rtl/numero_decoder.sv
// Debounced decoder of a 5-bit display code into a BCD digit, with a
// four-digit history. States: IDLE wait ready edge | CHECK stability count |
// DECODE commit digit | HOLD wait ready low.
module numero_decoder #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic     clock,
  input  logic     reset,
  numero_if.slave  bus
);

  localparam logic [2:0] STABLE = 3'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, CHECK, DECODE, HOLD} state_t;

  state_t      state_q, state_d;
  logic        ready_q;
  logic [4:0]  code_q;
  logic [2:0]  match_q;
  logic [3:0]  digit_q;
  logic        valid_q;
  logic        red_q;
  logic [15:0] value_q;
  logic [2:0]  count_q;

  logic [4:0]  code_in;
  logic        rise;
  logic        latch_code;
  logic        inc_match;
  logic        do_decode;
  logic        code_ok;
  logic [3:0]  code_digit;

  assign code_in = {bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
  assign rise    = bus.ready & ~ready_q;

  always_comb begin
    code_ok    = 1'b1;
    code_digit = 4'd0;
    case (code_q)
      5'b00000: code_digit = 4'd0;
      5'b10000: code_digit = 4'd1;
      5'b11000: code_digit = 4'd2;
      5'b11100: code_digit = 4'd3;
      5'b11110: code_digit = 4'd4;
      5'b11111: code_digit = 4'd5;
      5'b01111: code_digit = 4'd6;
      5'b00111: code_digit = 4'd7;
      5'b00011: code_digit = 4'd8;
      5'b00001: code_digit = 4'd9;
      default:  code_ok    = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (rise) state_d = CHECK;
      CHECK: begin
        if (!bus.ready) state_d = IDLE;
        else if (code_in == code_q && match_q == STABLE) state_d = DECODE;
      end
      DECODE: state_d = HOLD;
      HOLD:   if (!bus.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A mismatch in CHECK restarts the stability count on the new code.
  always_comb begin
    latch_code = 1'b0;
    inc_match  = 1'b0;
    do_decode  = 1'b0;
    case (state_q)
      IDLE:   latch_code = rise;
      CHECK: begin
        if (bus.ready) begin
          if (code_in != code_q) latch_code = 1'b1;
          else                   inc_match  = (match_q != STABLE);
        end
      end
      DECODE: do_decode = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b1;
      code_q  <= '0;
      match_q <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      red_q   <= 1'b0;
      value_q <= '0;
      count_q <= '0;
    end else begin
      ready_q <= bus.ready;
      valid_q <= 1'b0;
      if (latch_code) begin
        code_q  <= code_in;
        match_q <= '0;
      end else if (inc_match) begin
        match_q <= match_q + 3'd1;
      end
      if (do_decode) begin
        if (code_ok) begin
          digit_q <= code_digit;
          valid_q <= 1'b1;
          red_q   <= 1'b0;
        end else begin
          red_q   <= 1'b1;
        end
      end
      // clear wins over the shift but still keeps a digit decoded this cycle
      if (bus.clear) begin
        value_q <= (do_decode && code_ok) ? {12'h000, code_digit} : 16'h0000;
        count_q <= (do_decode && code_ok) ? 3'd1 : 3'd0;
      end else if (do_decode && code_ok) begin
        value_q <= {value_q[11:0], code_digit};
        count_q <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
      end
    end
  end

  assign {bus.A, bus.B, bus.C, bus.D} = digit_q;
  assign bus.valid          = valid_q;
  assign bus.Ativa_vermelho = red_q;
  assign bus.value          = value_q;
  assign bus.count          = count_q;
  assign bus.full           = (count_q == 3'd4);

endmodule
